alu_issue_stage: RTL

- Two-stage valid/ready pipeline wrapped around the 32-bit ALU datapath.
- Stage S1 registers incoming operations and drives the ALU operand and control inputs.
- Stage S2 captures the ALU result and flags, and presents them downstream to writeback.
- Also masks flags that have no meaning for the opcode, flags illegal opcodes and keeps a saturating overflow counter.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_pipe_reg.sv | 38 +++
 rtl/alu_issue_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and opcode classification helpers.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // True for the six control codes the ALU implements.
  function automatic logic is_legal_ctl(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True only where signed overflow carries meaning.
  function automatic logic is_arith_ctl(input logic [3:0] ctl);
    return (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_reg.sv
// Generic one-entry valid/ready pipeline register carrying WIDTH bits.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: in_ready_o = empty or downstream ready, so full throughput with no bubble.
module alu_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;
  logic             load;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign valid_d     = load || (valid_q && !out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Valid tracks occupancy; data only moves on an accepted transfer so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue pipeline around the ALU: S1 drives ALU inputs, S2 registers masked result/flags.
// Latency: op accepted at edge N is presented on out_* after edge N+1.
// Backpressure: in_ready is combinational from out_ready; 1 op/cycle while out_ready=1.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_ctl,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       ctl;
    logic             legal;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } s2_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             s1_valid, s2_valid, s2_free, s2_load;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Legality is decoded on entry so S2 only sees a single registered bit.
  assign s1_d.a     = in_a;
  assign s1_d.b     = in_b;
  assign s1_d.ctl   = in_ctl;
  assign s1_d.legal = is_legal_ctl(in_ctl);
  assign s1_d.tag   = in_tag;

  alu_pipe_reg #(.WIDTH($bits(s1_t))) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (s1_d),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_free),
    .out_data_o (s1_q)
  );

  // ALU inputs come straight from S1 so they stay stable while S1 holds.
  assign alu_a   = s1_q.a;
  assign alu_b   = s1_q.b;
  assign alu_ctl = s1_q.ctl;

  // Illegal opcodes squash result/zero; overflow only survives for ADD/SUB.
  assign s2_d.result   = s1_q.legal ? alu_result : 32'd0;
  assign s2_d.zero     = s1_q.legal && alu_zero;
  assign s2_d.overflow = alu_overflow && s1_q.legal && is_arith_ctl(s1_q.ctl);
  assign s2_d.illegal  = !s1_q.legal;
  assign s2_d.tag      = s1_q.tag;

  alu_pipe_reg #(.WIDTH($bits(s2_t))) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_free),
    .in_data_i  (s2_d),
    .out_valid_o(s2_valid),
    .out_ready_i(out_ready),
    .out_data_o (s2_q)
  );

  assign out_valid    = s2_valid;
  assign out_result   = s2_q.result;
  assign out_zero     = s2_q.zero;
  assign out_overflow = s2_q.overflow;
  assign out_illegal  = s2_q.illegal;
  assign out_tag      = s2_q.tag;

  assign s2_load   = s1_valid && s2_free;
  assign ovf_cnt_d = (s2_load && s2_d.overflow && (ovf_cnt_q != CNT_MAX))
                     ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;

  // Saturating count of overflowing results, counted as they enter S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;

endmodule
